// File: rtl/seg_scan_scheduler.sv
// Shared 8-digit seven-segment controller: round-robin req/gnt writes into a display buffer plus digit scan.
// Optional decimal-point support is enabled by defining SEG_DP_EN.
module seg_scan_scheduler #(
    parameter int unsigned SCAN_DIV = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_a,
    input  logic [2:0] digit_a,
    input  logic [3:0] code_a,
    input  logic       req_b,
    input  logic [2:0] digit_b,
    input  logic [3:0] code_b,
`ifdef SEG_DP_EN
    input  logic       dp_a,
    input  logic       dp_b,
`endif
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [7:0] led_en,
    output logic [6:0] seg,
    output logic       led_dp
);

    localparam logic [19:0] TC = 20'(SCAN_DIV);

    // Segment patterns are {g..a}, active low.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            4'd10:   s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [7:0][3:0] code_q, code_d;
    logic [19:0]     timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic            last_q, last_d;   // 1 = B won most recently
    logic            gnt_a_q, gnt_a_d;
    logic            gnt_b_q, gnt_b_d;
    logic [7:0]      led_en_q, led_en_d;
    logic [6:0]      seg_q, seg_d;
    logic            elig_a, elig_b, win_a, win_b;
`ifdef SEG_DP_EN
    logic [7:0]      dp_q, dp_d;
    logic            led_dp_q, led_dp_d;
`endif

    always_comb begin
        // A requester is blocked during its own grant cycle.
        elig_a  = req_a & ~gnt_a_q;
        elig_b  = req_b & ~gnt_b_q;
        win_a   = elig_a & (~elig_b | last_q);
        win_b   = elig_b & ~win_a;
        gnt_a_d = win_a;
        gnt_b_d = win_b;
        last_d  = win_a ? 1'b0 : (win_b ? 1'b1 : last_q);

        code_d = code_q;
`ifdef SEG_DP_EN
        dp_d = dp_q;
`endif
        if (win_a) begin
            code_d[digit_a] = code_a;
`ifdef SEG_DP_EN
            dp_d[digit_a] = dp_a;
`endif
        end else if (win_b) begin
            code_d[digit_b] = code_b;
`ifdef SEG_DP_EN
            dp_d[digit_b] = dp_b;
`endif
        end

        timer_d  = timer_q;
        idx_d    = idx_q;
        led_en_d = 8'hFF;
        seg_d    = 7'h7F;
`ifdef SEG_DP_EN
        led_dp_d = 1'b1;
`endif
        if (enable) begin
            if (timer_q == TC) begin
                timer_d = 20'd0;
                idx_d   = idx_q + 3'd1;
            end else begin
                timer_d = timer_q + 20'd1;
            end
            // Select and segments both follow idx_d so they switch on the same edge.
            led_en_d = ~(8'd1 << idx_d);
            seg_d    = decode(code_q[idx_d]);
`ifdef SEG_DP_EN
            led_dp_d = ~dp_q[idx_d];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= {8{4'hF}};
            timer_q  <= 20'd0;
            idx_q    <= 3'd0;
            last_q   <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            led_en_q <= 8'hFF;
            seg_q    <= 7'h7F;
`ifdef SEG_DP_EN
            dp_q     <= 8'h00;
            led_dp_q <= 1'b1;
`endif
        end else begin
            code_q   <= code_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            led_en_q <= led_en_d;
            seg_q    <= seg_d;
`ifdef SEG_DP_EN
            dp_q     <= dp_d;
            led_dp_q <= led_dp_d;
`endif
        end
    end

    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
    assign led_en = led_en_q;
    assign seg    = seg_q;
`ifdef SEG_DP_EN
    assign led_dp = led_dp_q;
`else
    assign led_dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: directed scenarios plus random traffic against a behavioural display model.
module tb_seg_scan_scheduler;

  localparam int SCAN_DIV = 15;
  localparam int PERIOD   = SCAN_DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] digit_a = '0, digit_b = '0;
  logic [3:0] code_a = '0, code_b = '0;
  logic       dp_a = 1'b0, dp_b = 1'b0;
  logic       gnt_a, gnt_b, led_dp;
  logic [7:0] led_en;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  seg_scan_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_a(req_a), .digit_a(digit_a), .code_a(code_a),
    .req_b(req_b), .digit_b(digit_b), .code_b(code_b),
`ifdef SEG_DP_EN
    .dp_a(dp_a), .dp_b(dp_b),
`endif
    .gnt_a(gnt_a), .gnt_b(gnt_b), .led_en(led_en), .seg(seg), .led_dp(led_dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: display contents, who won last, and how many enabled clocks have elapsed.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  end

  logic [3:0] m_code [8] = '{default: 4'hF};
  logic       m_dp [8] = '{default: 1'b0};
  int         m_last = 2;  // 1 = A, 2 = B
  logic       m_gnt_a = 1'b0, m_gnt_b = 1'b0;
  int         en_cnt = 0;
  logic [7:0] e_led_en = 8'hFF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] old_code [8];
    logic       old_dp [8];
    int winner, pos;
    if (!rst_n) begin
      m_code = '{default: 4'hF};
      m_dp = '{default: 1'b0};
      m_last = 2;
      m_gnt_a = 0; m_gnt_b = 0;
      en_cnt = 0;
      e_led_en = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      old_code = m_code;
      old_dp = m_dp;
      winner = 0;
      if (req_a && !m_gnt_a && req_b && !m_gnt_b) winner = (m_last == 2) ? 1 : 2;
      else if (req_a && !m_gnt_a) winner = 1;
      else if (req_b && !m_gnt_b) winner = 2;
      if (winner == 1) begin m_code[digit_a] = code_a; m_dp[digit_a] = dp_a; end
      if (winner == 2) begin m_code[digit_b] = code_b; m_dp[digit_b] = dp_b; end
      if (winner != 0) m_last = winner;
      m_gnt_a = (winner == 1);
      m_gnt_b = (winner == 2);
      if (enable) begin
        en_cnt++;
        pos = (en_cnt / PERIOD) % 8;
        e_led_en = ~(8'd1 << pos);
        e_seg = seg_tab[old_code[pos]];
`ifdef SEG_DP_EN
        e_dp = ~old_dp[pos];
`else
        e_dp = 1'b1;
`endif
      end else begin
        e_led_en = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("led_en", led_en, e_led_en);
      check("seg", seg, e_seg);
      check("led_dp", led_dp, e_dp);
      check("gnt_a", gnt_a, m_gnt_a);
      check("gnt_b", gnt_b, m_gnt_b);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete handshake: raise req, hold until gnt is seen, then drop.
  task automatic do_write(input int who, input int d, input int c, input bit dp);
    int k;
    @(negedge clk);
    if (who == 1) begin req_a = 1; digit_a = 3'(d); code_a = 4'(c); dp_a = dp; end
    else begin req_b = 1; digit_b = 3'(d); code_b = 4'(c); dp_b = dp; end
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((who == 1 && gnt_a) || (who == 2 && gnt_b)) break;
    end
    check("write_gnt_seen", (k < 10), 1);
    if (who == 1) req_a = 0; else req_b = 0;
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!req_a) begin
        if ($urandom_range(2) == 0) begin
          req_a = 1; digit_a = 3'($urandom_range(7)); code_a = 4'($urandom_range(15)); dp_a = 1'($urandom_range(1));
        end
      end else if (gnt_a) begin
        if ($urandom_range(1) == 0) req_a = 0;
        else begin digit_a = 3'($urandom_range(7)); code_a = 4'($urandom_range(15)); dp_a = 1'($urandom_range(1)); end
      end
      if (!req_b) begin
        if ($urandom_range(2) == 0) begin
          req_b = 1; digit_b = 3'($urandom_range(7)); code_b = 4'($urandom_range(15)); dp_b = 1'($urandom_range(1));
        end
      end else if (gnt_b) begin
        if ($urandom_range(1) == 0) req_b = 0;
        else begin digit_b = 3'($urandom_range(7)); code_b = 4'($urandom_range(15)); dp_b = 1'($urandom_range(1)); end
      end
      if ($urandom_range(39) == 0) enable = ~enable;
    end
    req_a = 0; req_b = 0;
  endtask

  initial begin
    int k;
    // Clock/reset
    cycles(2);
    chk_en = 1;
    check("rst_led_en", led_en, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    rst_n = 1;
    cycles(2);

    // Both requesters hold req on digit 5: A first, then strict alternation.
    req_a = 1; digit_a = 3'd5; code_a = 4'd1;
    req_b = 1; digit_b = 3'd5; code_b = 4'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_gnt_a", gnt_a, (i % 2 == 0));
      check("alt_gnt_b", gnt_b, (i % 2 == 1));
    end
    req_a = 0; req_b = 0;

    // Scan walk through all digits and wrap.
    enable = 1;
    cycles(9 * PERIOD + 3);
    do_write(1, 0, 3, 1'b1);
    cycles(8 * PERIOD);

    // Disable at digit 4, write while disabled, re-enable resumes at digit 4.
    for (k = 0; k < 10 * PERIOD; k++) begin
      @(negedge clk);
      if (led_en == 8'hEF) break;
    end
    check("reach_idx4", (k < 10 * PERIOD), 1);
    enable = 0;
    @(negedge clk);
    check("dis_led_en", led_en, 8'hFF);
    check("dis_seg", seg, 7'h7F);
    do_write(2, 4, 8, 1'b0);
    cycles(5);
    enable = 1;
    @(negedge clk);
    check("reen_led_en", led_en, 8'hEF);
    cycles(2 * PERIOD);

    // Random traffic.
    random_phase(2500);
    enable = 1;
    cycles(8 * PERIOD);

    // Asynchronous reset in the middle of a gnt_b pulse.
    @(negedge clk);
    req_b = 1; digit_b = 3'd2; code_b = 4'd9; dp_b = 1;
    for (k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (gnt_b) break;
    end
    check("gnt_b_before_rst", gnt_b, 1);
    rst_n = 0;
    #1;
    check("async_gnt_b", gnt_b, 0);
    check("async_led_en", led_en, 8'hFF);
    check("async_seg", seg, 7'h7F);
    check("async_led_dp", led_dp, 1);
    req_b = 0;
    cycles(2);
    rst_n = 1;
    cycles(9 * PERIOD);
    do_write(2, 2, 4, 1'b1);
    cycles(9 * PERIOD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
